// File: rtl/npu_stream_loader_if.sv
// Host-write and memory-write bundle for npu_stream_loader.
//   Host side : wr_valid, writedata (to loader); wr_ready (from loader)
//   Image RAM : img_we (per bank), img_addr (shared), img_wdata (bank k at [k*BYTE_W +: BYTE_W])
//   Weight RAM: wgt_we, wgt_addr, wgt_wdata
// master = host/bench side, slave = loader side.
interface npu_stream_loader_if #(
  parameter int DATA_W    = 32,
  parameter int BYTE_W    = 8,
  parameter int NUM_BANKS = 4,
  parameter int ADDR_W    = 16
);
  logic                        wr_valid;
  logic [DATA_W-1:0]           writedata;
  logic                        wr_ready;
  logic [NUM_BANKS-1:0]        img_we;
  logic [ADDR_W-1:0]           img_addr;
  logic [NUM_BANKS*BYTE_W-1:0] img_wdata;
  logic                        wgt_we;
  logic [ADDR_W-1:0]           wgt_addr;
  logic [BYTE_W-1:0]           wgt_wdata;

  modport master (
    output wr_valid, writedata,
    input  wr_ready, img_we, img_addr, img_wdata, wgt_we, wgt_addr, wgt_wdata
  );

  modport slave (
    input  wr_valid, writedata,
    output wr_ready, img_we, img_addr, img_wdata, wgt_we, wgt_addr, wgt_wdata
  );
endinterface

// File: rtl/npu_stream_loader.sv
// npu_stream_loader: writes the host writedata stream into the NPU image banks
// and weight RAM ahead of compute.
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   control_reg  : [1:0] mode (0/2 idle/clear, 1 full load, 3 weights-only)
//   bus (slave)  : host handshake plus registered image/weight RAM write ports
//   load_done    : load finished, compute may start
//   err_overflow : sticky, host wrote after the load had finished
// An image beat is unpacked MSB-first: bank 0 receives the top byte of writedata.
// A weight beat carries one byte in writedata[BYTE_W-1:0].
module npu_stream_loader #(
  parameter int DATA_W    = 32,
  parameter int BYTE_W    = 8,
  parameter int NUM_BANKS = 4,
  parameter int IMG_WORDS = 224,
  parameter int WGT_BYTES = 37630,
  parameter int ADDR_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          control_reg,
  npu_stream_loader_if.slave   bus,
  output logic                 load_done,
  output logic                 err_overflow
);

  localparam logic [ADDR_W-1:0] IMG_LAST = ADDR_W'(IMG_WORDS - 1);
  localparam logic [ADDR_W-1:0] WGT_LAST = ADDR_W'(WGT_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD_IMG,
    LOAD_WGT,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0]           img_cnt, img_cnt_nx;
  logic [ADDR_W-1:0]           wgt_cnt, wgt_cnt_nx;
  logic [NUM_BANKS-1:0]        img_we_nx;
  logic [ADDR_W-1:0]           img_addr_nx;
  logic [NUM_BANKS*BYTE_W-1:0] img_wdata_nx;
  logic                        wgt_we_nx;
  logic [ADDR_W-1:0]           wgt_addr_nx;
  logic [BYTE_W-1:0]           wgt_wdata_nx;
  logic                        load_done_nx;
  logic                        err_overflow_nx;

  logic [1:0] mode;
  logic       stop;
  logic       beat;
  logic       unused_ctrl;

  assign mode        = control_reg[1:0];
  // Modes 0 and 2 both mean idle: abort a load or clear a finished one.
  assign stop        = ~mode[0];
  assign beat        = bus.wr_valid & bus.wr_ready;
  assign unused_ctrl = ^control_reg[31:2];

  always_comb begin
    state_nx        = state;
    img_cnt_nx      = img_cnt;
    wgt_cnt_nx      = wgt_cnt;
    img_we_nx       = '0;
    img_addr_nx     = bus.img_addr;
    img_wdata_nx    = bus.img_wdata;
    wgt_we_nx       = 1'b0;
    wgt_addr_nx     = bus.wgt_addr;
    wgt_wdata_nx    = bus.wgt_wdata;
    load_done_nx    = load_done;
    err_overflow_nx = err_overflow;
    bus.wr_ready    = 1'b0;

    unique case (state)
      IDLE: begin
        img_cnt_nx = '0;
        wgt_cnt_nx = '0;
        if (mode == 2'd1) begin
          state_nx = LOAD_IMG;
        end else if (mode == 2'd3) begin
          state_nx = LOAD_WGT;
        end
      end

      LOAD_IMG: begin
        bus.wr_ready = 1'b1;
        if (beat) begin
          img_we_nx   = '1;
          img_addr_nx = img_cnt;
          for (int unsigned k = 0; k < NUM_BANKS; k++) begin
            img_wdata_nx[k*BYTE_W +: BYTE_W] = bus.writedata[DATA_W-1-k*BYTE_W -: BYTE_W];
          end
          if (img_cnt == IMG_LAST) begin
            img_cnt_nx = '0;
            wgt_cnt_nx = '0;
            state_nx   = LOAD_WGT;
          end else begin
            img_cnt_nx = img_cnt + ADDR_W'(1);
          end
        end
        // Abort overrides the beat's state advance; the beat itself is still written.
        if (stop) begin
          img_cnt_nx = '0;
          wgt_cnt_nx = '0;
          state_nx   = IDLE;
        end
      end

      LOAD_WGT: begin
        bus.wr_ready = 1'b1;
        if (beat) begin
          wgt_we_nx    = 1'b1;
          wgt_addr_nx  = wgt_cnt;
          wgt_wdata_nx = bus.writedata[BYTE_W-1:0];
          if (wgt_cnt == WGT_LAST) begin
            wgt_cnt_nx = '0;
            state_nx   = DONE;
          end else begin
            wgt_cnt_nx = wgt_cnt + ADDR_W'(1);
          end
        end
        if (stop) begin
          img_cnt_nx = '0;
          wgt_cnt_nx = '0;
          state_nx   = IDLE;
        end
      end

      DONE: begin
        // Registered, so load_done rises one cycle after the last wgt_we cycle.
        load_done_nx = 1'b1;
        if (bus.wr_valid) begin
          err_overflow_nx = 1'b1;
        end
        if (stop) begin
          load_done_nx    = 1'b0;
          err_overflow_nx = 1'b0;
          state_nx        = IDLE;
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      img_cnt       <= '0;
      wgt_cnt       <= '0;
      bus.img_we    <= '0;
      bus.img_addr  <= '0;
      bus.img_wdata <= '0;
      bus.wgt_we    <= 1'b0;
      bus.wgt_addr  <= '0;
      bus.wgt_wdata <= '0;
      load_done     <= 1'b0;
      err_overflow  <= 1'b0;
    end else begin
      state         <= state_nx;
      img_cnt       <= img_cnt_nx;
      wgt_cnt       <= wgt_cnt_nx;
      bus.img_we    <= img_we_nx;
      bus.img_addr  <= img_addr_nx;
      bus.img_wdata <= img_wdata_nx;
      bus.wgt_we    <= wgt_we_nx;
      bus.wgt_addr  <= wgt_addr_nx;
      bus.wgt_wdata <= wgt_wdata_nx;
      load_done     <= load_done_nx;
      err_overflow  <= err_overflow_nx;
    end
  end

endmodule

// File: tb/tb_npu_stream_loader.sv
// Scoreboard bench for npu_stream_loader. Instance A uses the default
// parameters; instance B is a small 2-bank, 16-bit variant. Drivers push the
// expected RAM write for each beat; per-instance monitors pop and compare
// whenever a write enable is seen.
module tb_npu_stream_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  logic [31:0] ctrl_a, ctrl_b;
  logic        done_a, ovf_a, done_b, ovf_b;
  bit          mon_a = 1'b0, mon_b = 1'b0;

  int errors = 0;
  int checks = 0;
  int nwr_a = 0, nimg_a = 0, nwr_b = 0;

  typedef struct {
    bit          is_img;
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t qa[$];
  wr_t qb[$];
  wr_t ea, eb;

  npu_stream_loader_if bus_a ();
  npu_stream_loader_if #(.DATA_W(16), .BYTE_W(8), .NUM_BANKS(2), .ADDR_W(8)) bus_b ();

  npu_stream_loader dut_a (
    .clk(clk), .reset(rst_a), .control_reg(ctrl_a), .bus(bus_a),
    .load_done(done_a), .err_overflow(ovf_a)
  );

  npu_stream_loader #(
    .DATA_W(16), .BYTE_W(8), .NUM_BANKS(2), .IMG_WORDS(6), .WGT_BYTES(5), .ADDR_W(8)
  ) dut_b (
    .clk(clk), .reset(rst_b), .control_reg(ctrl_b), .bus(bus_b),
    .load_done(done_b), .err_overflow(ovf_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] img_word_a(input int i);
    return 32'h01020304 + 32'(i) * 32'h04040404;
  endfunction

  function automatic logic [31:0] wgt_word_a(input int j);
    return 32'hC3A50000 | ((32'(j) * 32'd7) & 32'h0000FFFF);
  endfunction

  function automatic logic [31:0] swap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  function automatic logic [15:0] img_word_b(input int i);
    return 16'h0102 + 16'(i) * 16'h0202;
  endfunction

  function automatic logic [15:0] wgt_word_b(input int j);
    return 16'hAB00 | 16'(j * 3 + 1);
  endfunction

  // Monitors: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (mon_a) begin
      if (bus_a.img_we !== 4'h0 || bus_a.wgt_we !== 1'b0) begin
        nwr_a++;
        if (bus_a.img_we !== 4'h0) nimg_a++;
        if (qa.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL a_unexpected_write: img_we=%b wgt_we=%b img_addr=%0d wgt_addr=%0d, expected no write",
                   bus_a.img_we, bus_a.wgt_we, bus_a.img_addr, bus_a.wgt_addr);
        end else begin
          ea = qa.pop_front();
          if (ea.is_img) begin
            check("a_img_we", 32'(bus_a.img_we), 32'hF);
            check("a_img_addr", 32'(bus_a.img_addr), ea.addr);
            check("a_img_data", bus_a.img_wdata, ea.data);
            check("a_wgt_we_off", 32'(bus_a.wgt_we), 32'h0);
          end else begin
            check("a_wgt_we", 32'(bus_a.wgt_we), 32'h1);
            check("a_wgt_addr", 32'(bus_a.wgt_addr), ea.addr);
            check("a_wgt_data", 32'(bus_a.wgt_wdata), ea.data);
            check("a_img_we_off", 32'(bus_a.img_we), 32'h0);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mon_b) begin
      if (bus_b.img_we !== 2'b00 || bus_b.wgt_we !== 1'b0) begin
        nwr_b++;
        if (qb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_unexpected_write: img_we=%b wgt_we=%b img_addr=%0d wgt_addr=%0d, expected no write",
                   bus_b.img_we, bus_b.wgt_we, bus_b.img_addr, bus_b.wgt_addr);
        end else begin
          eb = qb.pop_front();
          if (eb.is_img) begin
            check("b_img_we", 32'(bus_b.img_we), 32'h3);
            check("b_img_addr", 32'(bus_b.img_addr), eb.addr);
            check("b_img_data", 32'(bus_b.img_wdata), eb.data);
            check("b_wgt_we_off", 32'(bus_b.wgt_we), 32'h0);
          end else begin
            check("b_wgt_we", 32'(bus_b.wgt_we), 32'h1);
            check("b_wgt_addr", 32'(bus_b.wgt_addr), eb.addr);
            check("b_wgt_data", 32'(bus_b.wgt_wdata), eb.data);
            check("b_img_we_off", 32'(bus_b.img_we), 32'h0);
          end
        end
      end
    end
  end

  // One host beat for instance A; when a write is expected, wr_ready must be high.
  task automatic beat_a(input logic [31:0] d, input bit exp_wr, input bit is_img,
                        input int addr, input logic [31:0] ed);
    if (exp_wr) begin
      qa.push_back('{is_img, addr, ed});
      check("a_wr_ready", 32'(bus_a.wr_ready), 32'h1);
    end
    bus_a.wr_valid  = 1'b1;
    bus_a.writedata = d;
    @(posedge clk);
    #1;
    bus_a.wr_valid  = 1'b0;
  endtask

  task automatic beat_b(input logic [15:0] d, input bit is_img, input int addr,
                        input logic [31:0] ed);
    qb.push_back('{is_img, addr, ed});
    check("b_wr_ready", 32'(bus_b.wr_ready), 32'h1);
    bus_b.wr_valid  = 1'b1;
    bus_b.writedata = d;
    @(posedge clk);
    #1;
    bus_b.wr_valid  = 1'b0;
  endtask

  task automatic cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero_a(input string tag);
    check({tag, "_ready"}, 32'(bus_a.wr_ready), 32'h0);
    check({tag, "_img_we"}, 32'(bus_a.img_we), 32'h0);
    check({tag, "_img_addr"}, 32'(bus_a.img_addr), 32'h0);
    check({tag, "_img_wdata"}, bus_a.img_wdata, 32'h0);
    check({tag, "_wgt_we"}, 32'(bus_a.wgt_we), 32'h0);
    check({tag, "_wgt_addr"}, 32'(bus_a.wgt_addr), 32'h0);
    check({tag, "_wgt_wdata"}, 32'(bus_a.wgt_wdata), 32'h0);
    check({tag, "_done"}, 32'(done_a), 32'h0);
    check({tag, "_ovf"}, 32'(ovf_a), 32'h0);
  endtask

  task automatic run_a;
    int img0;
    rst_a = 1'b1;
    ctrl_a = 32'h0;
    bus_a.wr_valid = 1'b0;
    bus_a.writedata = '0;
    cycle();
    cycle();
    mon_a = 1'b1;
    check_zero_a("a_reset");
    rst_a = 1'b0;

    // Full default load, back-to-back; upper control bits must be ignored.
    ctrl_a = 32'hFFFF_FFFD;
    cycle();
    for (int i = 0; i < 224; i++) beat_a(img_word_a(i), 1, 1, i, swap32(img_word_a(i)));
    for (int j = 0; j < 37630; j++) beat_a(wgt_word_a(j), 1, 0, j, wgt_word_a(j) & 32'hFF);
    check("a_last_wgt_we", 32'(bus_a.wgt_we), 32'h1);
    check("a_last_wgt_addr", 32'(bus_a.wgt_addr), 32'd37629);
    check("a_done_early", 32'(done_a), 32'h0);
    cycle();
    check("a_done", 32'(done_a), 32'h1);
    check("a_wgt_we_after", 32'(bus_a.wgt_we), 32'h0);
    check("a_queue_t1", qa.size(), 32'h0);

    // Overflow: extra beat in DONE is refused and flagged.
    check("a_done_ready", 32'(bus_a.wr_ready), 32'h0);
    beat_a(32'hDEADBEEF, 0, 0, 0, 0);
    check("a_ovf_set", 32'(ovf_a), 32'h1);
    check("a_done_hold", 32'(done_a), 32'h1);
    ctrl_a = 32'h0;
    cycle();
    check("a_clear_done", 32'(done_a), 32'h0);
    check("a_clear_ovf", 32'(ovf_a), 32'h0);

    // Abort: word 100 arrives in the abort cycle and is still written.
    ctrl_a = 32'h1;
    cycle();
    for (int i = 0; i < 100; i++) beat_a(img_word_a(i), 1, 1, i, swap32(img_word_a(i)));
    ctrl_a = 32'h0;
    beat_a(img_word_a(100), 1, 1, 100, swap32(img_word_a(100)));
    check("a_abort_idle", 32'(bus_a.wr_ready), 32'h0);
    cycle();
    check("a_abort_ready", 32'(bus_a.wr_ready), 32'h0);
    ctrl_a = 32'h1;
    cycle();
    beat_a(32'h11223344, 1, 1, 0, 32'h44332211);
    beat_a(32'hA0B0C0D0, 1, 1, 1, 32'hD0C0B0A0);
    ctrl_a = 32'h2;
    beat_a(32'h55667788, 1, 1, 2, 32'h88776655);
    cycle();
    check("a_queue_t5", qa.size(), 32'h0);
    check("a_abort_done", 32'(done_a), 32'h0);

    // Reset at weight byte 500: the beat in the reset cycle is discarded.
    ctrl_a = 32'h1;
    cycle();
    for (int i = 0; i < 224; i++) beat_a(img_word_a(i), 1, 1, i, swap32(img_word_a(i)));
    for (int j = 0; j < 500; j++) beat_a(wgt_word_a(j), 1, 0, j, wgt_word_a(j) & 32'hFF);
    rst_a = 1'b1;
    beat_a(wgt_word_a(500), 0, 0, 0, 0);
    check_zero_a("a_midreset");
    rst_a = 1'b0;
    cycle();
    beat_a(32'h0A0B0C0D, 1, 1, 0, 32'h0D0C0B0A);
    beat_a(32'hF1F2F3F4, 1, 1, 1, 32'hF4F3F2F1);
    ctrl_a = 32'h0;
    beat_a(32'h12345678, 1, 1, 2, 32'h78563412);
    cycle();
    check("a_queue_t6", qa.size(), 32'h0);

    // Weights-only; a switch to mode 1 mid-load must be ignored.
    img0 = nimg_a;
    ctrl_a = 32'h3;
    cycle();
    for (int j = 0; j < 37630; j++) begin
      if (j == 1000) ctrl_a = 32'h1;
      beat_a(wgt_word_a(j), 1, 0, j, wgt_word_a(j) & 32'hFF);
    end
    check("a_w_done_early", 32'(done_a), 32'h0);
    cycle();
    check("a_w_done", 32'(done_a), 32'h1);
    check("a_w_no_img_we", nimg_a - img0, 32'h0);
    check("a_queue_t3", qa.size(), 32'h0);
    ctrl_a = 32'h0;
    cycle();
    check("a_w_clear", 32'(done_a), 32'h0);
  endtask

  task automatic run_b;
    int w0;
    rst_b = 1'b1;
    ctrl_b = 32'h0;
    bus_b.wr_valid = 1'b0;
    bus_b.writedata = '0;
    cycle();
    cycle();
    mon_b = 1'b1;
    check("b_reset_img_we", 32'(bus_b.img_we), 32'h0);
    check("b_reset_wgt_we", 32'(bus_b.wgt_we), 32'h0);
    check("b_reset_done", 32'(done_b), 32'h0);
    check("b_reset_ready", 32'(bus_b.wr_ready), 32'h0);
    rst_b = 1'b0;

    // Back-to-back load on the 2-bank variant: 0x0102 -> bank0=01, bank1=02.
    ctrl_b = 32'h1;
    cycle();
    for (int i = 0; i < 6; i++)
      beat_b(img_word_b(i), 1, i, 32'({img_word_b(i)[7:0], img_word_b(i)[15:8]}));
    for (int j = 0; j < 5; j++) beat_b(wgt_word_b(j), 0, j, 32'(wgt_word_b(j)[7:0]));
    check("b_done_early", 32'(done_b), 32'h0);
    cycle();
    check("b_done", 32'(done_b), 32'h1);
    ctrl_b = 32'h0;
    cycle();

    // Same load with a bubble after every beat.
    w0 = nwr_b;
    ctrl_b = 32'h1;
    cycle();
    for (int n = 0; n < 11; n++) begin
      if (n < 6) beat_b(img_word_b(n), 1, n, 32'({img_word_b(n)[7:0], img_word_b(n)[15:8]}));
      else       beat_b(wgt_word_b(n - 6), 0, n - 6, 32'(wgt_word_b(n - 6)[7:0]));
      if (n < 10) begin
        bus_b.writedata = 16'hFFFF;
        cycle();
      end
    end
    check("b_bub_done_early", 32'(done_b), 32'h0);
    cycle();
    check("b_bub_done", 32'(done_b), 32'h1);
    check("b_bub_writes", nwr_b - w0, 32'd11);
    check("b_queue", qb.size(), 32'h0);
    ctrl_b = 32'h0;
    cycle();
  endtask

  initial begin
    fork
      run_a();
      run_b();
    join
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
